// File: rtl/player_move_ctrl.sv
// Player movement sequencer: button vector to single-pixel steps with auto-repeat,
// gated by the AND of all rectangle enables and by the playfield bounds.
module player_move_ctrl #(
  parameter int N_RECT        = 4,
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int PLAYER_SIZE   = 12,
  parameter int H_START       = 314,
  parameter int V_START       = 234,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 2
) (
  input  logic              btnClk,
  input  logic              rst,
  input  logic [3:0]        btns,
  input  logic [N_RECT-1:0] up_en,
  input  logic [N_RECT-1:0] down_en,
  input  logic [N_RECT-1:0] left_en,
  input  logic [N_RECT-1:0] right_en,
  output logic [31:0]       player_hPos,
  output logic [31:0]       player_vPos,
  output logic [3:0]        move_dir,
  output logic              move_valid,
  output logic              blocked
);

  // state | meaning
  // IDLE  | no request pending, waiting for a button
  // STEP  | single cycle, apply or deny one pixel step
  // WAIT  | spacing down-counter running before the next repeat step
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // STEP and the WAIT->STEP transition edge each consume one cycle of the spacing.
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 2);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 2);

  localparam logic [3:0] DIR_U = 4'b1000;
  localparam logic [3:0] DIR_D = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_L = 4'b0001;

  logic [1:0]       state;
  logic [3:0]       btnQ;
  logic [3:0]       dirSel;
  logic [CNT_W-1:0] count;
  logic             first;
  logic             allow;

  always_comb begin
    dirSel = 4'b0000;
    if (btnQ[3])      dirSel = DIR_U;
    else if (btnQ[2]) dirSel = DIR_D;
    else if (btnQ[1]) dirSel = DIR_R;
    else if (btnQ[0]) dirSel = DIR_L;
  end

  // Bounds written as plain comparisons so nothing can underflow at zero.
  always_comb begin
    allow = 1'b0;
    case (move_dir)
      DIR_U:   allow = (&up_en)    && (player_vPos != 32'd0);
      DIR_D:   allow = (&down_en)  && ((player_vPos + 32'(PLAYER_SIZE)) < 32'(V_RES));
      DIR_R:   allow = (&right_en) && ((player_hPos + 32'(PLAYER_SIZE)) < 32'(H_RES));
      DIR_L:   allow = (&left_en)  && (player_hPos != 32'd0);
      default: allow = 1'b0;
    endcase
  end

  always_ff @(posedge btnClk) begin
    if (rst) begin
      state       <= IDLE;
      btnQ        <= 4'b0000;
      count       <= '0;
      first       <= 1'b0;
      move_dir    <= 4'b0000;
      move_valid  <= 1'b0;
      blocked     <= 1'b0;
      player_hPos <= 32'(H_START);
      player_vPos <= 32'(V_START);
    end else begin
      btnQ       <= btns;
      move_valid <= 1'b0;
      blocked    <= 1'b0;
      case (state)
        IDLE: begin
          if (dirSel != 4'b0000) begin
            move_dir <= dirSel;
            first    <= 1'b1;
            state    <= STEP;
          end
        end
        STEP: begin
          if (allow) begin
            move_valid <= 1'b1;
            case (move_dir)
              DIR_U:   player_vPos <= player_vPos - 32'd1;
              DIR_D:   player_vPos <= player_vPos + 32'd1;
              DIR_R:   player_hPos <= player_hPos + 32'd1;
              DIR_L:   player_hPos <= player_hPos - 32'd1;
              default: ;
            endcase
          end else begin
            blocked <= 1'b1;
          end
          count <= first ? DELAY_LOAD : PERIOD_LOAD;
          first <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (dirSel == 4'b0000) begin
            state <= IDLE;
          end else if (dirSel != move_dir) begin
            move_dir <= dirSel;
            first    <= 1'b1;
            state    <= STEP;
          end else if (count == '0) begin
            first <= 1'b0;
            state <= STEP;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: directed scenarios plus random traffic, compared each
// cycle against a step-schedule model built on absolute edge numbers.
module tb_player_move_ctrl;

  logic        btnClk = 1'b0;
  logic        rst;
  logic [3:0]  btns;
  logic [3:0]  upEn, downEn, leftEn, rightEn;
  logic [31:0] hPos, vPos;
  logic [3:0]  moveDir;
  logic        moveValid, blocked;

  always #5 btnClk = ~btnClk;

  player_move_ctrl dut (
    .btnClk     (btnClk),
    .rst        (rst),
    .btns       (btns),
    .up_en      (upEn),
    .down_en    (downEn),
    .left_en    (leftEn),
    .right_en   (rightEn),
    .player_hPos(hPos),
    .player_vPos(vPos),
    .move_dir   (moveDir),
    .move_valid (moveValid),
    .blocked    (blocked)
  );

  int checks = 0;
  int errors = 0;

  // Model: position, last direction, request being served and the edge of the next step.
  int         mH, mV;
  logic [3:0] mDir, mBtnQ, reqDir;
  logic       mValid, mBlk, mFirst;
  int         cyc = 0;
  int         stepAt = -1;

  int nValid, nBlk;
  int validEdges[$];

  function automatic logic [3:0] prio(input logic [3:0] b);
    if (b[3]) return 4'b1000;
    if (b[2]) return 4'b0100;
    if (b[1]) return 4'b0010;
    if (b[0]) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelEdge();
    logic [3:0] dq;
    logic ok;
    dq = prio(mBtnQ);
    mValid = 1'b0;
    mBlk = 1'b0;
    if (rst) begin
      mH = 314; mV = 234; mDir = 4'b0000; mBtnQ = 4'b0000;
      reqDir = 4'b0000; mFirst = 1'b0; stepAt = -1;
    end else begin
      if (stepAt == cyc) begin
        case (mDir)
          4'b1000: ok = (&upEn)    && mV > 0;
          4'b0100: ok = (&downEn)  && mV + 12 < 480;
          4'b0010: ok = (&rightEn) && mH + 12 < 640;
          default: ok = (&leftEn)  && mH > 0;
        endcase
        if (ok) begin
          mValid = 1'b1;
          if (mDir == 4'b1000) mV = mV - 1;
          else if (mDir == 4'b0100) mV = mV + 1;
          else if (mDir == 4'b0010) mH = mH + 1;
          else mH = mH - 1;
        end else begin
          mBlk = 1'b1;
        end
        stepAt = cyc + (mFirst ? 8 : 2);
        mFirst = 1'b0;
      end else if (reqDir == 4'b0000) begin
        if (dq != 4'b0000) begin
          reqDir = dq; mDir = dq; mFirst = 1'b1; stepAt = cyc + 1;
        end
      end else if (dq == 4'b0000) begin
        reqDir = 4'b0000; stepAt = -1;
      end else if (dq != reqDir) begin
        reqDir = dq; mDir = dq; mFirst = 1'b1; stepAt = cyc + 1;
      end
      mBtnQ = btns;
    end
  endtask

  task automatic tick();
    @(posedge btnClk);
    modelEdge();
    #1;
    if (moveValid === 1'b1) begin nValid++; validEdges.push_back(cyc); end
    if (blocked === 1'b1) nBlk++;
    chk("hPos", hPos, 32'(mH));
    chk("vPos", vPos, 32'(mV));
    chk("moveDir", {28'd0, moveDir}, {28'd0, mDir});
    chk("moveValid", {31'd0, moveValid}, {31'd0, mValid});
    chk("blocked", {31'd0, blocked}, {31'd0, mBlk});
    chk("pulseExcl", {31'd0, moveValid & blocked}, 32'd0);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    nValid = 0; nBlk = 0; validEdges.delete();
  endtask

  task automatic doReset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  int e0, savedV;

  initial begin
    rst = 1'b1; btns = 4'b1000;
    upEn = 4'hF; downEn = 4'hF; leftEn = 4'hF; rightEn = 4'hF;
    mH = 314; mV = 234; mDir = 0; mBtnQ = 0; reqDir = 0; mFirst = 0;
    clr();

    // reset with a button held
    tick();
    chk("rstH", hPos, 32'd314);
    chk("rstV", vPos, 32'd234);
    chk("rstDir", {28'd0, moveDir}, 32'd0);
    chk("rstValid", {31'd0, moveValid}, 32'd0);
    chk("rstBlk", {31'd0, blocked}, 32'd0);
    rst = 1'b0; btns = 4'b0000;
    tick();
    chk("postRstV", vPos, 32'd234);
    chk("postRstValid", {31'd0, moveValid}, 32'd0);
    run(3);

    // single tap down
    clr();
    e0 = cyc; btns = 4'b0100; tick(); btns = 4'b0000;
    run(10);
    chk("tapCount", 32'(nValid), 32'd1);
    chk("tapLatency", 32'(validEdges.size() > 0 ? validEdges[0] - e0 : -1), 32'd2);
    chk("tapV", vPos, 32'd235);
    chk("tapDir", {28'd0, moveDir}, 32'b0100);

    // auto-repeat up
    clr();
    btns = 4'b1000; run(30); btns = 4'b0000; run(6);
    savedV = vPos;
    chk("repCount", 32'(validEdges.size() >= 4), 32'd1);
    if (validEdges.size() >= 4) begin
      chk("repGap0", 32'(validEdges[1] - validEdges[0]), 32'd8);
      chk("repGap1", 32'(validEdges[2] - validEdges[1]), 32'd2);
      chk("repGap2", 32'(validEdges[3] - validEdges[2]), 32'd2);
    end
    run(10);
    chk("repFrozen", vPos, 32'(savedV));

    // collision gate on down
    doReset();
    clr();
    downEn = 4'b1101; btns = 4'b0100; run(20); btns = 4'b0000; run(4);
    chk("gateValid", 32'(nValid), 32'd0);
    chk("gateBlk", 32'(nBlk > 0), 32'd1);
    chk("gateV", vPos, 32'd234);
    downEn = 4'hF;

    // priority, direction change mid-wait, reset during wait
    doReset();
    btns = 4'b1010; run(4);
    chk("prioV", vPos, 32'd233);
    clr();
    e0 = cyc; btns = 4'b0010; run(14);
    chk("chgH", 32'(hPos > 314), 32'd1);
    if (validEdges.size() >= 2) begin
      chk("chgLatency", 32'(validEdges[0] - e0), 32'd2);
      chk("chgGap", 32'(validEdges[1] - validEdges[0]), 32'd8);
    end else begin
      chk("chgSteps", 32'(validEdges.size()), 32'd2);
    end
    run(3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("wrstH", hPos, 32'd314);
    chk("wrstV", vPos, 32'd234);
    chk("wrstValid", {31'd0, moveValid}, 32'd0);
    btns = 4'b0000; run(4);

    // bounds: right edge, left step back, top edge, bottom edge
    btns = 4'b0010; run(700);
    chk("rEdgeH", hPos, 32'd628);
    clr(); run(10);
    chk("rEdgeValid", 32'(nValid), 32'd0);
    chk("rEdgeBlk", 32'(nBlk > 0), 32'd1);
    btns = 4'b0000; run(3);
    btns = 4'b0001; tick(); btns = 4'b0000; run(5);
    chk("lStepH", hPos, 32'd627);
    btns = 4'b1000; run(500);
    chk("uEdgeV", vPos, 32'd0);
    clr(); run(10);
    chk("uEdgeBlk", 32'(nBlk > 0 && nValid == 0), 32'd1);
    btns = 4'b0100; run(1000);
    chk("dEdgeV", vPos, 32'd468);
    btns = 4'b0000; run(3);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      btns = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      upEn    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      downEn  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      leftEn  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      rightEn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      rst = ($urandom_range(0, 60) == 0);
      tick();
      rst = 1'b0;
      run($urandom_range(0, 12));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Sequences player movement for the 640x480 playfield. It turns the raw 4-bit button vector into single-pixel step commands with auto-repeat. Each step is gated by the per-rectangle direction enables (AND across all rectangles) and by the screen bounds. It owns the authoritative player position that feeds every rectangle's `player_hPos`/`player_vPos` inputs, so it is the scheduler sitting between the buttons and the rectangle collision datapath.

## Interface
Parameters:
- N_RECT, 4, number of rectangle instances supplying enables
- H_RES, 640, horizontal playfield width in pixels
- V_RES, 480, vertical playfield height in pixels
- PLAYER_SIZE, 12, player square edge in pixels
- H_START, 314, player hPos after reset
- V_START, 234, player vPos after reset
- REPEAT_DELAY, 8, cycles from first step to second step while held (>=2)
- REPEAT_PERIOD, 2, cycles between later steps while held (>=2)

Ports:
- btnClk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- btns  in  4  button vector: bit3 = U, bit2 = D, bit1 = R, bit0 = L
- up_en  in  N_RECT  per-rectangle upEnable
- down_en  in  N_RECT  per-rectangle downEnable
- left_en  in  N_RECT  per-rectangle leftEnable
- right_en  in  N_RECT  per-rectangle rightEnable
- player_hPos  out  32  player left edge, registered
- player_vPos  out  32  player top edge, registered
- move_dir  out  4  one-hot direction of the current/last step command, same bit order as btns
- move_valid  out  1  one-cycle pulse, position changed this edge
- blocked  out  1  one-cycle pulse, step attempted but denied

## Operation
- Input stage: btns registered into btn_q every edge. Direction is decoded from btn_q with fixed priority U > D > R > L, producing the one-hot dir_sel. btn_q = 0 means no request.
- States:
  - IDLE: if dir_sel != 0, latch dir and move to STEP with first = 1.
  - STEP (one cycle): evaluate allow. On allow, apply ±1 to the axis and pulse move_valid. Otherwise pulse blocked. Then go to WAIT, loading the counter for a spacing of REPEAT_DELAY if first = 1, else REPEAT_PERIOD. Clear first.
  - WAIT: each cycle, check in this order:
    - dir_sel = 0 → IDLE.
    - dir_sel != latched dir → STEP next edge with the new dir and first = 1.
    - Counter expired → STEP with first = 0.
    - Otherwise decrement the counter.
- allow is the AND-reduction of the selected direction's enable vector, ANDed with the bound test:
  - U: vPos > 0
  - D: vPos + PLAYER_SIZE < V_RES
  - L: hPos > 0
  - R: hPos + PLAYER_SIZE < H_RES
- No wrap-around. Movement saturates at the edges, unlike rectangle movement.
- Enables are sampled at the STEP edge, as current input values. A one-cycle staleness from the rectangle registers is accepted.
- Arithmetic is 32-bit unsigned. Bound comparisons must not underflow; compare vPos > 0, never vPos - 1 >= 0.
- move_dir holds the last latched dir. It is 0 only after reset.

## Timing
- Reset: on the rst edge, player_hPos = H_START, player_vPos = V_START, move_dir = 0, move_valid = 0, blocked = 0, btn_q = 0, state = IDLE, counter = 0, first = 0. This applies mid-STEP or mid-WAIT too: no step occurs on a reset edge.
- Latency: btns is sampled at edge k (btn_q), IDLE→STEP at k+1, and the position/pulse update at k+2.
- Held button: STEP edges at s, s+REPEAT_DELAY, then every REPEAT_PERIOD cycles.
- Release: with btn_q = 0 seen in WAIT, no further step occurs and the block is in IDLE one edge later. A STEP already entered still completes.
- Pulses: move_valid and blocked are mutually exclusive and high for exactly one cycle per STEP.
- Throughput: at most one step per 2 cycles.

## Test plan
- Reset: assert rst 1 cycle while btns = 4'b1000 → hPos = 314, vPos = 234, move_valid = 0, blocked = 0, move_dir = 0, with no step on the following edge.
- Single tap: btns = 4'b0100 for 1 cycle, all enables = 4'hF → exactly one move_valid, 2 edges after sampling; vPos = 235; move_dir = 4'b0100.
- Auto-repeat: hold btns = 4'b1000 for 30 cycles, enables all 1 → vPos decrements at s, s+8, s+10, s+12, …; after release, vPos is frozen and state returns to IDLE.
- Collision gate: down_en = 4'b1101, btns = 4'b0100 held → blocked pulse on each STEP, vPos stays 234, move_valid never asserted.
- Boundary: H_START = 628 → R request gives blocked with hPos = 628; L request gives move_valid with hPos = 627. V_START = 0 → U request gives blocked.
- Priority/change/reset: btns = 4'b1010 → U wins (vPos - 1). Switch to 4'b0010 mid-WAIT → R step on the next STEP edge, with REPEAT_DELAY spacing restarted. Assert rst during WAIT → position restored, IDLE, no pulse.
